// File: rtl/uart_access_arbiter.sv
// Two-requester arbiter in front of a UART register port.
// Round-robin grant, one-cycle access, one-cycle ack, and TX write pacing via gap_cnt.
module uart_access_arbiter #(
    parameter logic [15:0] TX_GAP = 16'd10416
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_write,
    input  logic [7:0]  r0_address,
    input  logic [7:0]  r0_wdata,
    output logic        r0_ack,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_write,
    input  logic [7:0]  r1_address,
    input  logic [7:0]  r1_wdata,
    output logic        r1_ack,
    output logic [31:0] r1_rdata,
    output logic        uart_selected,
    output logic [7:0]  uart_address,
    output logic        uart_write,
    output logic        uart_read,
    output logic [7:0]  uart_in_data,
    input  logic [31:0] uart_out_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t      state, state_next;
    logic        win, last_grant, lat_write;
    logic [7:0]  lat_address, lat_wdata;
    logic [15:0] gap_cnt;
    logic        tx_blocked, elig0, elig1, grant, start;

    // A TX write is only held off while the pacing gap is still running.
    assign tx_blocked = (gap_cnt != 16'd0);
    assign elig0 = r0_req && !(r0_write && (r0_address == 8'd8) && tx_blocked);
    assign elig1 = r1_req && !(r1_write && (r1_address == 8'd8) && tx_blocked);
    assign grant = (elig0 && elig1) ? ~last_grant : elig1;
    assign start = (state == IDLE) && (elig0 || elig1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        uart_write   = 1'b0;
        uart_read    = 1'b0;
        uart_address = 8'd0;
        uart_in_data = 8'd0;
        r0_ack       = 1'b0;
        r1_ack       = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 || elig1) state_next = ACCESS;
            end
            ACCESS: begin
                state_next   = ACK;
                uart_write   = lat_write;
                uart_read    = !lat_write;
                uart_address = lat_address;
                uart_in_data = lat_wdata;
            end
            ACK: begin
                state_next = IDLE;
                r0_ack     = !win;
                r1_ack     = win;
            end
            default: state_next = IDLE;
        endcase
    end

    assign uart_selected = (state == ACCESS) || tx_blocked;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win         <= 1'b0;
            last_grant  <= 1'b1;
            lat_write   <= 1'b0;
            lat_address <= 8'd0;
            lat_wdata   <= 8'd0;
            gap_cnt     <= 16'd0;
            r0_rdata    <= 32'd0;
            r1_rdata    <= 32'd0;
        end else begin
            if (start) begin
                win         <= grant;
                last_grant  <= grant;
                lat_write   <= grant ? r1_write   : r0_write;
                lat_address <= grant ? r1_address : r0_address;
                lat_wdata   <= grant ? r1_wdata   : r0_wdata;
            end
            if ((state == ACCESS) && lat_write && (lat_address == 8'd8))
                gap_cnt <= TX_GAP;
            else if (tx_blocked)
                gap_cnt <= gap_cnt - 16'd1;
            if ((state == ACCESS) && !lat_write) begin
                if (win) r1_rdata <= uart_out_data;
                else     r0_rdata <= uart_out_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_access_arbiter.sv
// Randomized bench for uart_access_arbiter against a transaction-level model,
// plus directed read, tie, pacing and reset-abort scenarios.
module tb_uart_access_arbiter;

    localparam logic [15:0] GAP = 16'd4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req, r0_write, r1_req, r1_write;
    logic [7:0]  r0_address, r0_wdata, r1_address, r1_wdata;
    logic        r0_ack, r1_ack;
    logic [31:0] r0_rdata, r1_rdata;
    logic        uart_selected, uart_write, uart_read;
    logic [7:0]  uart_address, uart_in_data;
    logic [31:0] uart_out_data;

    logic        s_req   [2];
    logic        s_write [2];
    logic [7:0]  s_addr  [2];
    logic [7:0]  s_wdata [2];

    assign r0_req     = s_req[0];
    assign r0_write   = s_write[0];
    assign r0_address = s_addr[0];
    assign r0_wdata   = s_wdata[0];
    assign r1_req     = s_req[1];
    assign r1_write   = s_write[1];
    assign r1_address = s_addr[1];
    assign r1_wdata   = s_wdata[1];

    always #5 clock = ~clock;

    uart_access_arbiter #(.TX_GAP(GAP)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_write(r0_write), .r0_address(r0_address), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_write(r1_write), .r1_address(r1_address), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .uart_selected(uart_selected), .uart_address(uart_address), .uart_write(uart_write),
        .uart_read(uart_read), .uart_in_data(uart_in_data), .uart_out_data(uart_out_data)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: m_busy counts remaining transaction cycles (2 = access next, 1 = ack next).
    int          m_busy, m_win, m_last, m_tx;
    logic        m_lw;
    logic [7:0]  m_la, m_ld;
    logic [31:0] m_rd [2];

    bit auto_en [2];
    bit rd_only, rnd_data;
    int ack_who[$];
    int ack_cyc[$];
    int wr8_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int gap_at(int c);
        int g;
        if (m_tx < 0) return 0;
        g = int'(GAP) - (c - m_tx - 1);
        return (g > 0) ? g : 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_win = 0; m_last = 1; m_tx = -1;
        m_lw = 1'b0; m_la = 8'd0; m_ld = 8'd0;
        m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    endtask

    task automatic advance();
        bit e [2];
        int g;
        if (m_busy == 2) begin
            if (!m_lw) m_rd[m_win] = uart_out_data;
            else if (m_la == 8'd8) m_tx = cyc;
            m_busy = 1;
        end else if (m_busy == 1) begin
            m_busy = 0;
        end else begin
            g = gap_at(cyc);
            for (int n = 0; n < 2; n++)
                e[n] = s_req[n] && !(s_write[n] && (s_addr[n] == 8'd8) && (g != 0));
            if (e[0] || e[1]) begin
                m_win  = (e[0] && e[1]) ? (1 - m_last) : (e[0] ? 0 : 1);
                m_last = m_win;
                m_lw   = s_write[m_win];
                m_la   = s_addr[m_win];
                m_ld   = s_wdata[m_win];
                m_busy = 2;
            end
        end
    endtask

    task automatic new_req(input int n);
        s_req[n]   = 1'b1;
        s_write[n] = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0:       s_addr[n] = 8'd0;
            1:       s_addr[n] = 8'd4;
            2, 3:    s_addr[n] = 8'd8;
            default: s_addr[n] = 8'($urandom_range(0, 255));
        endcase
        s_wdata[n] = 8'($urandom);
    endtask

    task automatic check_reset_outputs();
        check("rst_selected", 32'(uart_selected), 32'd0);
        check("rst_uart_write", 32'(uart_write), 32'd0);
        check("rst_uart_read", 32'(uart_read), 32'd0);
        check("rst_uart_address", 32'(uart_address), 32'd0);
        check("rst_uart_in_data", 32'(uart_in_data), 32'd0);
        check("rst_r0_ack", 32'(r0_ack), 32'd0);
        check("rst_r1_ack", 32'(r1_ack), 32'd0);
        check("rst_r0_rdata", r0_rdata, 32'd0);
        check("rst_r1_rdata", r1_rdata, 32'd0);
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
    endtask

    // Commit this cycle's inputs to the model, move to the next mid-cycle and check outputs.
    task automatic tick();
        bit acc, akp, ak;
        if (reset) model_reset();
        else       advance();
        @(negedge clock);
        cyc++;
        acc = (m_busy == 2);
        akp = (m_busy == 1);
        check("uart_write", 32'(uart_write), 32'(acc && m_lw));
        check("uart_read", 32'(uart_read), 32'(acc && !m_lw));
        check("uart_address", 32'(uart_address), acc ? 32'(m_la) : 32'd0);
        check("uart_in_data", 32'(uart_in_data), acc ? 32'(m_ld) : 32'd0);
        check("uart_selected", 32'(uart_selected), 32'(acc || (gap_at(cyc) != 0)));
        check("r0_ack", 32'(r0_ack), 32'(akp && (m_win == 0)));
        check("r1_ack", 32'(r1_ack), 32'(akp && (m_win == 1)));
        check("r0_rdata", r0_rdata, m_rd[0]);
        check("r1_rdata", r1_rdata, m_rd[1]);
        if (r0_ack) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
        if (r1_ack) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
        if (uart_write && (uart_address == 8'd8)) wr8_cyc.push_back(cyc);
        for (int n = 0; n < 2; n++) begin
            if (auto_en[n]) begin
                ak = (n == 0) ? r0_ack : r1_ack;
                if (ak) begin
                    if (rd_only || ($urandom_range(0, 1) == 1)) new_req(n);
                    else s_req[n] = 1'b0;
                end else if (!s_req[n] && ($urandom_range(0, 2) == 0)) begin
                    new_req(n);
                end
            end
        end
        if (rnd_data) uart_out_data = $urandom;
    endtask

    initial begin : main
        int t0, rel, n0, r1c, rc;
        for (int n = 0; n < 2; n++) begin
            s_req[n] = 1'b0; s_write[n] = 1'b0; s_addr[n] = 8'd0; s_wdata[n] = 8'd0;
            auto_en[n] = 1'b0;
        end
        rd_only = 1'b0; rnd_data = 1'b0; uart_out_data = 32'd0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Mid-cycle reset with nothing pending.
        assert_reset();
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Single read of address 4.
        uart_out_data = 32'h1;
        s_req[0] = 1'b1; s_write[0] = 1'b0; s_addr[0] = 8'd4;
        t0 = cyc;
        ack_cyc.delete(); ack_who.delete();
        repeat (5) begin
            tick();
            if (r0_ack) begin
                check("read_latency", 32'(cyc - t0), 32'd2);
                check("read_rdata", r0_rdata, 32'h1);
                check("read_other_ack", 32'(r1_ack), 32'd0);
                s_req[0] = 1'b0;
            end
        end
        check("read_ack_count", 32'(ack_cyc.size()), 32'd1);

        // Both requesters reading continuously from reset.
        assert_reset();
        rd_only = 1'b1;
        new_req(0); new_req(1);
        auto_en[0] = 1'b1; auto_en[1] = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        rel = cyc;
        ack_cyc.delete(); ack_who.delete();
        repeat (13) tick();
        check("tie_ack_count", 32'(ack_who.size() >= 4), 32'd1);
        if (ack_who.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("tie_order", 32'(ack_who[i]), 32'(i % 2));
                check("tie_ack_cycle", 32'(ack_cyc[i] - rel), 32'(2 + 3 * i));
            end
        end
        auto_en[0] = 1'b0; auto_en[1] = 1'b0; rd_only = 1'b0;
        s_req[0] = 1'b0; s_req[1] = 1'b0;
        repeat (4) tick();

        // Two paced TX writes with an r1 read slotted into the gap.
        assert_reset();
        tick();
        reset = 1'b0;
        s_req[0] = 1'b1; s_write[0] = 1'b1; s_addr[0] = 8'd8; s_wdata[0] = 8'h41;
        uart_out_data = 32'hCAFE_0004;
        wr8_cyc.delete(); ack_cyc.delete(); ack_who.delete();
        n0 = 0; r1c = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (r0_ack) begin
                n0++;
                if (n0 == 1) begin
                    s_wdata[0] = 8'h42;
                    s_req[1] = 1'b1; s_write[1] = 1'b0; s_addr[1] = 8'd4;
                end else begin
                    s_req[0] = 1'b0;
                end
            end
            if (r1_ack) begin
                s_req[1] = 1'b0;
                r1c = cyc;
            end
        end
        check("pace_write_count", 32'(wr8_cyc.size()), 32'd2);
        if (wr8_cyc.size() == 2) begin
            check("pace_spacing", 32'(wr8_cyc[1] - wr8_cyc[0]), 32'(int'(GAP) + 2));
            check("pace_r1_in_gap", 32'((r1c > wr8_cyc[0]) && (r1c < wr8_cyc[1])), 32'd1);
        end

        // Reset during r1 ACCESS aborts it; the held request is served again.
        s_req[1] = 1'b1; s_write[1] = 1'b0; s_addr[1] = 8'd0;
        uart_out_data = 32'h0000_00A5;
        repeat (8) begin
            if (uart_read) break;
            tick();
        end
        check("abort_in_access", 32'(uart_read), 32'd1);
        ack_cyc.delete(); ack_who.delete();
        assert_reset();
        repeat (2) tick();
        check("abort_no_ack", 32'(ack_cyc.size()), 32'd0);
        reset = 1'b0;
        rel = cyc;
        rc = -1;
        repeat (6) begin
            tick();
            if (r1_ack && (rc < 0)) begin
                rc = cyc;
                s_req[1] = 1'b0;
            end
        end
        check("abort_reack_latency", 32'(rc - rel), 32'd2);

        // Randomized traffic with occasional resets.
        auto_en[0] = 1'b1; auto_en[1] = 1'b1; rnd_data = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 499) == 0) begin
                assert_reset();
                tick();
                reset = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
